// File: rtl/hp0_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : hp0_wr_arbiter
// Brief   : Round-robin share of the single-beat HP0 AXI write path between
//           ADC capture (0) and loop telemetry (1), with per-requester DDR ring
//           addressing and outstanding-write accounting.
// Option  : define WR_ARB_STATS_EN to add beats0_o/beats1_o/stall_o counters.
// Revision: 1.0 - initial release
// ============================================================================
module hp0_wr_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 24,
    parameter int MAX_OUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [ADDR_W-1:0] base0_i,
    input  logic [LEN_W-1:0]  len0_i,
    input  logic [ADDR_W-1:0] base1_i,
    input  logic [LEN_W-1:0]  len1_i,
    input  logic              req0_valid_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic              bvalid_i,
    output logic              wrap0_o,
    output logic              wrap1_o,
    output logic [7:0]        outstanding_o,
    output logic              idle_o,
    output logic              err_o
`ifdef WR_ARB_STATS_EN
    ,
    output logic [31:0]       beats0_o,
    output logic [31:0]       beats1_o,
    output logic [31:0]       stall_o
`endif
);

    localparam int         c_BYTES   = DATA_W / 8;
    localparam logic [7:0] c_MAX_OUT = 8'(MAX_OUT);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                gnt_q, gnt_d;
    logic [LEN_W-1:0]    offset0_q, offset0_d;
    logic [LEN_W-1:0]    offset1_q, offset1_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                wrap0_q, wrap0_d;
    logic                wrap1_q, wrap1_d;
    logic [7:0]          outstanding_q, outstanding_d;
    logic                err_q, err_d;

    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_grant;
    logic                w_win;
    logic                w_done;
    logic                w_last0;
    logic                w_last1;
    logic [ADDR_W-1:0]   w_addr0;
    logic [ADDR_W-1:0]   w_addr1;

    assign w_aw_hs = awvalid_q & awready_i;
    assign w_w_hs  = wvalid_q & wready_i;
    assign w_grant = (state_q == ST_IDLE) && enable_i && (outstanding_q < c_MAX_OUT)
                     && (req0_valid_i || req1_valid_i);
    // Pointer's requester wins if it is valid, otherwise the other one must be.
    assign w_win   = ptr_q ? req1_valid_i : ~req0_valid_i;
    assign w_done  = (state_q == ST_ISSUE) && (!awvalid_q || awready_i)
                     && (!wvalid_q || wready_i);

    // ">=" so a ring shortened below its current offset still wraps on completion.
    assign w_last0 = (len0_i == '0) || (offset0_q >= (len0_i - LEN_W'(1)));
    assign w_last1 = (len1_i == '0) || (offset1_q >= (len1_i - LEN_W'(1)));
    assign w_addr0 = base0_i + (ADDR_W'(offset0_q) * ADDR_W'(c_BYTES));
    assign w_addr1 = base1_i + (ADDR_W'(offset1_q) * ADDR_W'(c_BYTES));

    assign req0_ready_o = w_grant & ~w_win;
    assign req1_ready_o = w_grant & w_win;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        offset0_d = offset0_q;
        offset1_d = offset1_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        wrap0_d   = 1'b0;
        wrap1_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!enable_i) begin
                    offset0_d = '0;
                    offset1_d = '0;
                end
                if (w_grant) begin
                    state_d   = ST_ISSUE;
                    gnt_d     = w_win;
                    awaddr_d  = w_win ? w_addr1 : w_addr0;
                    wdata_d   = w_win ? req1_data_i : req0_data_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (w_aw_hs) begin
                    awvalid_d = 1'b0;
                end
                if (w_w_hs) begin
                    wvalid_d = 1'b0;
                end
                if (w_done) begin
                    state_d = ST_IDLE;
                    ptr_d   = ~gnt_q;
                    if (!gnt_q) begin
                        if (w_last0) begin
                            offset0_d = '0;
                            wrap0_d   = 1'b1;
                        end else begin
                            offset0_d = offset0_q + LEN_W'(1);
                        end
                    end else begin
                        if (w_last1) begin
                            offset1_d = '0;
                            wrap1_d   = 1'b1;
                        end else begin
                            offset1_d = offset1_q + LEN_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A response with nothing outstanding is a protocol error; the count never underflows.
    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (bvalid_i && (outstanding_q == 8'd0)) begin
            err_d = 1'b1;
            if (w_aw_hs) begin
                outstanding_d = 8'd1;
            end
        end else if (w_aw_hs && !bvalid_i) begin
            outstanding_d = outstanding_q + 8'd1;
        end else if (!w_aw_hs && bvalid_i) begin
            outstanding_d = outstanding_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= 1'b0;
            gnt_q         <= 1'b0;
            offset0_q     <= '0;
            offset1_q     <= '0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            wrap0_q       <= 1'b0;
            wrap1_q       <= 1'b0;
            outstanding_q <= 8'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            gnt_q         <= gnt_d;
            offset0_q     <= offset0_d;
            offset1_q     <= offset1_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            wrap0_q       <= wrap0_d;
            wrap1_q       <= wrap1_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign awaddr_o      = awaddr_q;
    assign awvalid_o     = awvalid_q;
    assign wdata_o       = wdata_q;
    assign wvalid_o      = wvalid_q;
    assign wrap0_o       = wrap0_q;
    assign wrap1_o       = wrap1_q;
    assign outstanding_o = outstanding_q;
    assign idle_o        = (state_q == ST_IDLE) && (outstanding_q == 8'd0);
    assign err_o         = err_q;

`ifdef WR_ARB_STATS_EN
    logic [31:0] beats0_q, beats0_d;
    logic [31:0] beats1_q, beats1_d;
    logic [31:0] stall_q, stall_d;
    logic        w_stall;

    assign w_stall = (req0_valid_i || req1_valid_i) && enable_i && (outstanding_q == c_MAX_OUT);

    always_comb begin
        beats0_d = beats0_q;
        beats1_d = beats1_q;
        stall_d  = stall_q;
        if (w_done && !gnt_q && (beats0_q != '1)) begin
            beats0_d = beats0_q + 32'd1;
        end
        if (w_done && gnt_q && (beats1_q != '1)) begin
            beats1_d = beats1_q + 32'd1;
        end
        if (w_stall && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beats0_q <= '0;
            beats1_q <= '0;
            stall_q  <= '0;
        end else begin
            beats0_q <= beats0_d;
            beats1_q <= beats1_d;
            stall_q  <= stall_d;
        end
    end

    assign beats0_o = beats0_q;
    assign beats1_o = beats1_q;
    assign stall_o  = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hp0_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_hp0_wr_arbiter
// Brief   : Directed plus randomized bench for hp0_wr_arbiter against a
//           transaction-level ring/arbitration/outstanding model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hp0_wr_arbiter;

    localparam int c_MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        enable;
    logic [31:0] base0, base1;
    logic [23:0] len0, len1;
    logic        v0, v1, r0, r1;
    logic [63:0] d0, d1;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic        wvalid, wready, bvalid;
    logic        wrap0, wrap1, idle, err;
    logic [7:0]  outstanding;

    hp0_wr_arbiter #(
        .ADDR_W (32),
        .DATA_W (64),
        .LEN_W  (24),
        .MAX_OUT(c_MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable),
        .base0_i      (base0),
        .len0_i       (len0),
        .base1_i      (base1),
        .len1_i       (len1),
        .req0_valid_i (v0),
        .req0_data_i  (d0),
        .req0_ready_o (r0),
        .req1_valid_i (v1),
        .req1_data_i  (d1),
        .req1_ready_o (r1),
        .awaddr_o     (awaddr),
        .awvalid_o    (awvalid),
        .awready_i    (awready),
        .wdata_o      (wdata),
        .wvalid_o     (wvalid),
        .wready_i     (wready),
        .bvalid_i     (bvalid),
        .wrap0_o      (wrap0),
        .wrap1_o      (wrap1),
        .outstanding_o(outstanding),
        .idle_o       (idle),
        .err_o        (err)
    );

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    // Reference model: one beat in flight, ring offsets advanced per grant.
    int          m_out;
    bit          m_err, busy, aw_pend, w_pend;
    bit          pend_wrap0, pend_wrap1, wrap_exp0, wrap_exp1;
    int          last_win;
    int          off0, off1;
    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_data_q[$];
    int          b_due[$];
    logic [31:0] aw_log[$];
    int          win_log[$];

    bit auto_rdy, auto_b, took0, took1;
    int aw_pct, w_pct, gap_pct, bmin, bmax, rem0, rem1;
    int wrap0_cnt, wvalid_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_err = 0; busy = 0; aw_pend = 0; w_pend = 0;
        pend_wrap0 = 0; pend_wrap1 = 0; wrap_exp0 = 0; wrap_exp1 = 0;
        last_win = 1; off0 = 0; off1 = 0; took0 = 0; took1 = 0;
        exp_addr_q.delete(); exp_data_q.delete(); b_due.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; bvalid = 1'b0; rem0 = 0; rem1 = 0;
        #1;
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_idle", idle, 1);
        chk("rst_err", err, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_ready", {r1, r0}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive();
        if (!v0 && rem0 > 0 && int'($urandom_range(99)) >= gap_pct) begin
            v0 = 1'b1; d0 = {$urandom, $urandom};
        end
        if (!v1 && rem1 > 0 && int'($urandom_range(99)) >= gap_pct) begin
            v1 = 1'b1; d1 = {$urandom, $urandom};
        end
        if (auto_rdy) begin
            awready = (int'($urandom_range(99)) < aw_pct);
            wready  = (int'($urandom_range(99)) < w_pct);
        end
        if (auto_b) begin
            bvalid = 1'b0;
            if (b_due.size() > 0 && b_due[0] <= cyc_n) begin
                bvalid = 1'b1;
                void'(b_due.pop_front());
            end
        end
    endtask

    task automatic tick();
        bit   busy0, aw_hs, w_hs, exp_gnt, win;
        int   n, lenv, lim;
        logic [31:0] a;
        #2;
        busy0 = busy;
        chk("outstanding", outstanding, m_out);
        chk("err", err, m_err);
        chk("idle", idle, (!busy0 && m_out == 0));
        chk("awvalid", awvalid, aw_pend);
        chk("wvalid", wvalid, w_pend);
        chk("wrap0", wrap0, wrap_exp0);
        chk("wrap1", wrap1, wrap_exp1);
        if (wrap0) wrap0_cnt++;
        if (wvalid) wvalid_cnt++;
        wrap_exp0 = 0; wrap_exp1 = 0;
        if (!enable && !busy0) begin off0 = 0; off1 = 0; end
        exp_gnt = enable && !busy0 && (m_out < c_MAX_OUT) && (v0 || v1);
        chk("grant", r0 | r1, exp_gnt);
        chk("ready_onehot", r0 & r1, 0);
        if (r0 || r1) begin
            win = r1;
            if (v0 && v1) chk("rr_alternate", win, (last_win == 0));
            else          chk("rr_only_valid", win, v1);
            last_win = int'(win);
            win_log.push_back(int'(win));
            n    = win ? off1 : off0;
            lenv = int'(win ? len1 : len0);
            lim  = (lenv == 0) ? 1 : lenv;
            a    = (win ? base1 : base0) + 32'(n * 8);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(win ? d1 : d0);
            if (n + 1 >= lim) begin
                n = 0;
                if (win) pend_wrap1 = 1; else pend_wrap0 = 1;
            end else begin
                n = n + 1;
            end
            if (win) begin off1 = n; took1 = 1; rem1--; end
            else     begin off0 = n; took0 = 1; rem0--; end
            busy = 1;
        end
        aw_hs = aw_pend && awready;
        w_hs  = w_pend && wready;
        if (aw_hs) begin
            chk("awaddr", awaddr, exp_addr_q.pop_front());
            aw_log.push_back(awaddr);
            aw_pend = 0;
            b_due.push_back(cyc_n + bmin + int'($urandom_range(bmax - bmin)));
        end
        if (w_hs) begin
            chk("wdata", wdata, exp_data_q.pop_front());
            w_pend = 0;
        end
        if (busy0 && !aw_pend && !w_pend) begin
            busy = 0;
            wrap_exp0 = pend_wrap0; wrap_exp1 = pend_wrap1;
            pend_wrap0 = 0; pend_wrap1 = 0;
        end
        if (!busy0 && busy) begin aw_pend = 1; w_pend = 1; end
        if (bvalid && m_out == 0) begin
            m_err = 1;
            m_out = m_out + int'(aw_hs);
        end else begin
            m_out = m_out + int'(aw_hs) - int'(bvalid);
        end
        @(posedge clk); #1;
        cyc_n++;
        if (took0) begin v0 = 1'b0; took0 = 0; end
        if (took1) begin v1 = 1'b0; took1 = 0; end
    endtask

    task automatic step();
        drive();
        tick();
    endtask

    task automatic flush_b();
        b_due.delete();
        for (int i = 0; i < m_out; i++) b_due.push_back(cyc_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a0;
        enable = 1'b0; base0 = '0; base1 = '0; len0 = '0; len1 = '0;
        d0 = '0; d1 = '0; awready = 1'b0; wready = 1'b0;
        auto_rdy = 1; auto_b = 1; aw_pct = 100; w_pct = 100; gap_pct = 0;
        bmin = 2; bmax = 2; wrap0_cnt = 0; wvalid_cnt = 0;
        model_reset();

        // Single requester, ring of 4 beats, B two cycles after AW.
        do_reset();
        enable = 1'b1; base0 = 32'h1000_0000; len0 = 24'd4;
        base1 = 32'h2000_0000; len1 = 24'd3;
        rem0 = 5; wrap0_cnt = 0; aw_log.delete();
        repeat (20) step();
        chk("t1_beats", aw_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            a0 = 32'h1000_0000 + 32'((i % 4) * 8);
            chk("t1_addr", (i < aw_log.size()) ? aw_log[i] : 32'hx, a0);
        end
        chk("t1_wrap_once", wrap0_cnt, 1);

        // Both requesters always valid: grants alternate.
        do_reset();
        enable = 1'b1; bmin = 1; bmax = 3;
        rem0 = 4; rem1 = 4; win_log.delete(); aw_log.delete();
        repeat (24) step();
        for (int i = 0; i < 4; i++)
            chk("t2_alternate", (i < win_log.size()) ? win_log[i] : -1, i % 2);
        chk("t2_ring1_first", (aw_log.size() > 1) ? aw_log[1] : 32'hx, 32'h2000_0000);
        chk("t2_ring0_second", (aw_log.size() > 2) ? aw_log[2] : 32'hx, 32'h1000_0008);
        chk("t2_ring1_second", (aw_log.size() > 3) ? aw_log[3] : 32'hx, 32'h2000_0008);

        // Back-pressure at MAX_OUT, then one response frees exactly one slot.
        do_reset();
        enable = 1'b1; auto_b = 0; bvalid = 1'b0;
        rem0 = 10; rem1 = 10; aw_log.delete();
        repeat (30) step();
        chk("t3_aw_at_limit", aw_log.size(), c_MAX_OUT);
        chk("t3_no_ready", r0 | r1, 0);
        bvalid = 1'b1; step(); bvalid = 1'b0;
        repeat (20) step();
        chk("t3_one_more", aw_log.size(), c_MAX_OUT + 1);
        rem0 = 0; rem1 = 0; flush_b(); auto_b = 1;
        repeat (20) step();

        // W handshake delayed three cycles after AW.
        do_reset();
        enable = 1'b1; auto_rdy = 0; awready = 1'b1; wready = 1'b0; rem0 = 2;
        step();
        wvalid_cnt = 0;
        step();
        awready = 1'b0;
        repeat (2) step();
        wready = 1'b1;
        step();
        chk("t4_wvalid_cycles", wvalid_cnt, 4);
        auto_rdy = 1;
        repeat (8) step();

        // Error on response at zero count; AW and B in the same cycle.
        do_reset();
        enable = 1'b1; auto_b = 0; bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        repeat (3) step();
        chk("t5_err_sticky", err, 1);
        chk("t5_count_zero", outstanding, 0);
        rem0 = 3;
        repeat (12) step();
        chk("t5_count_three", outstanding, 3);
        rem0 = 1;
        for (int k = 0; k < 10 && !awvalid; k++) step();
        chk("t5_aw_seen", awvalid, 1);
        bvalid = 1'b1; step(); bvalid = 1'b0;
        step();
        chk("t5_same_cycle", outstanding, 3);
        flush_b(); auto_b = 1;
        repeat (10) step();

        // enable falls mid-ISSUE: beat completes, no new grant, offsets cleared.
        do_reset();
        enable = 1'b1; base0 = 32'h3000_0000; len0 = 24'd8;
        rem0 = 3;
        repeat (8) step();
        rem0 = 1; auto_rdy = 0; awready = 1'b0; wready = 1'b0;
        step();
        enable = 1'b0;
        repeat (2) step();
        awready = 1'b1; wready = 1'b1;
        step();
        auto_rdy = 1; rem0 = 2;
        repeat (5) step();
        enable = 1'b1; aw_log.delete();
        repeat (8) step();
        chk("t6_offset_cleared", (aw_log.size() > 0) ? aw_log[0] : 32'hx, 32'h3000_0000);

        // Asynchronous reset during ISSUE drops the valids at once.
        repeat (6) step();
        rem0 = 1; auto_rdy = 0; awready = 1'b0; wready = 1'b0;
        step();
        chk("t6_in_issue", awvalid, 1);
        #2; rst = 1'b1; #1;
        chk("t6_rst_awvalid", awvalid, 0);
        chk("t6_rst_wvalid", wvalid, 0);
        @(posedge clk); #1;
        v0 = 1'b0; rem0 = 0; rst = 1'b0; auto_rdy = 1;
        model_reset();

        // Randomized traffic.
        do_reset();
        enable = 1'b1; aw_pct = 70; w_pct = 60; gap_pct = 30; bmin = 1; bmax = 6;
        base0 = $urandom & 32'hFFFF_FFF8; base1 = $urandom & 32'hFFFF_FFF8;
        len0 = 24'($urandom_range(5)); len1 = 24'($urandom_range(5));
        rem0 = 60; rem1 = 60;
        for (int c = 0; c < 800; c++) begin
            if (!busy && $urandom_range(99) < 3) begin
                len0 = 24'($urandom_range(5)); len1 = 24'($urandom_range(5));
                base0 = $urandom & 32'hFFFF_FFF8;
            end
            if ($urandom_range(99) < 2) enable = ~enable;
            step();
        end
        enable = 1'b1; rem0 = 0; rem1 = 0; aw_pct = 100; w_pct = 100;
        repeat (40) step();
        chk("rand_drained", outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
